panel_frame_receiver: RTL and testbench
=======================================

# panel_frame_receiver

Panel-side receiver for the LED daisy-chain serial link. It samples the serial data, shift-clock and latch lines driven by the panel serializer and assembles 128 bits into sixteen 8-bit device bytes. On a latch it publishes a complete frame, and it flags frames that are short or over-long. It sits at the panel end of the link, opposite the serializer that drives the four 32-bit source registers out MSB-first.

## Interface
Parameters:
- NUM_DEV, 16, number of 8-bit devices in the chain; frame length is 8*NUM_DEV bits.
- SYNC_STAGES, 2, synchronizer depth on each link input (≥2).

Ports:
- clk  in  1  system clock; link inputs are asynchronous to it.
- rst  in  1  asynchronous, active-low reset.
- sdi  in  1  serial data, MSB of frame first.
- sclk  in  1  link shift clock; data is sampled on its rising edge.
- lat  in  1  link latch; its rising edge publishes the frame.
- out_bytes  out  [NUM_DEV-1:0][7:0]  published device bytes; out_bytes[k] drives device k.
- frame_valid  out  1  one-cycle pulse: out_bytes was updated.
- frame_err  out  1  one-cycle pulse: latch seen with bit count ≠ 8*NUM_DEV.
- busy  out  1  high while state ≠ IDLE.

## Operation
- sdi, sclk and lat each pass through SYNC_STAGES flops.
- sclk and lat additionally get a registered rising-edge detect.
- On each sclk edge: shift_reg <= {shift_reg[FRAME_BITS-2:0], sdi_s}.
- Mapping after a full frame: out_bytes[k] = shift_reg[8k+7:8k]. The first bit received lands in out_bytes[NUM_DEV-1][7].
- bit_cnt counts sclk edges and saturates at FRAME_BITS+1. Width is clog2(FRAME_BITS+2).
- States:
  - IDLE: bit_cnt = 0.
  - SHIFTING: 0 < bit_cnt < FRAME_BITS.
  - FULL: bit_cnt = FRAME_BITS.
  - OVERRUN: more than FRAME_BITS edges seen. Shifting continues, as in a real chain, so the last FRAME_BITS bits are retained.
- Transitions:
  - IDLE→SHIFTING on the first sclk edge.
  - SHIFTING→FULL on the FRAME_BITS-th edge.
  - FULL→OVERRUN on a further edge.
  - Any state→IDLE on a lat edge.
- lat edge in FULL: copy shift_reg to out_bytes, pulse frame_valid.
- lat edge in IDLE, SHIFTING or OVERRUN: out_bytes holds, pulse frame_err. An IDLE latch with 0 bits is an error.
- Every lat edge clears bit_cnt. shift_reg is not cleared.
- Simultaneous sclk and lat edge in the same cycle: the shift and count update apply first. The latch decision uses the updated count, and the latched data includes the new bit.

## Timing
- Reset values: out_bytes = 0, frame_valid = 0, frame_err = 0, busy = 0, shift_reg = 0, bit_cnt = 0, state = IDLE.
- Reset asserted mid-frame discards the partial frame. No pulse is emitted.
- sclk pin edge to shift_reg update: SYNC_STAGES+1 clk cycles.
- lat pin edge to out_bytes/frame_valid: SYNC_STAGES+1 cycles. frame_valid and out_bytes change in the same cycle.
- sclk high and low phases must each last ≥ SYNC_STAGES clk cycles. Faster toggling is out of spec.
- sdi must be stable from SYNC_STAGES cycles before to 1 cycle after the sclk rising edge.
- frame_valid and frame_err are mutually exclusive and never exceed one cycle.

## Structure
- Package panel_pkg holds:
  - NUM_DEV and FRAME_BITS = 8*NUM_DEV;
  - the bit-count width;
  - the state enum rx_state_t {IDLE, SHIFTING, FULL, OVERRUN};
  - the device-byte typedef dev_byte_t = logic [7:0].
- Sub-module link_sync: a SYNC_STAGES synchronizer with optional rising-edge output. It is instantiated for sdi (level only), sclk and lat.
- Top holds the shift register, counter, FSM and output register.

## Test plan
- Reset then idle: rst low 7 cycles → out_bytes = 0, busy = 0, no pulses.
- Nominal frame: send 128'h0000000B_0000000B_0000000B_0000000B MSB-first, then lat.
  - Expected: frame_valid pulses once; out_bytes[0], [4], [8] and [12] = 8'h0B; all others 0; frame_err stays 0.
- Short frame: send 127 bits, then lat → frame_err pulses once, out_bytes unchanged from the previous frame, busy = 0.
- Overrun: send 130 bits with the first two = 1 and the rest = 8'hA5 pattern, then lat → frame_err pulses and out_bytes is unchanged.
  - A following nominal 128-bit frame gives frame_valid.
- Coincident edges: align the 128th sclk rise and the lat rise on the same sampled cycle.
  - Expected: frame_valid pulses and out_bytes[0][0] equals the 128th bit.
- Reset mid-frame: assert rst after 64 bits, release, then send a full 128-bit frame of all 1s and lat.
  - Expected: out_bytes = all 8'hFF and exactly one frame_valid pulse.

Source files
------------

// File: rtl/panel_pkg.sv
// Shared constants and types for the panel-side LED chain receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package panel_pkg;

  localparam int NUM_DEV    = 16;
  localparam int FRAME_BITS = 8 * NUM_DEV;
  // Counter must hold FRAME_BITS+1 (saturated overrun marker).
  localparam int CNT_W      = $clog2(FRAME_BITS + 2);

  typedef enum logic [1:0] {
    IDLE,
    SHIFTING,
    FULL,
    OVERRUN
  } rx_state_t;

  typedef logic [7:0] dev_byte_t;

endpackage

// File: rtl/link_sync.sv
// Multi-flop synchronizer for one asynchronous link line, optional rising-edge strobe.
// Latency: STAGES clk cycles to q; rise is asserted in the same cycle q first goes high.
// Backpressure: none; the link is push-only and cannot be stalled.
module link_sync #(
  parameter int STAGES  = 2,
  parameter bit EDGE_EN = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise
);

  logic [STAGES-1:0] sync;
  logic              prev;

  // Shift the raw pin through the synchronizer chain and remember the last settled level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      prev <= sync[STAGES-1];
    end
  end

  assign q    = sync[STAGES-1];
  assign rise = EDGE_EN ? (q & ~prev) : 1'b0;

endmodule

// File: rtl/panel_frame_receiver.sv
// Panel-end receiver: shifts 8*NUM_DEV serial bits and publishes them as device bytes on latch.
// Latency: SYNC_STAGES+1 clk cycles from sclk/lat pin edge to shift_reg / out_bytes update.
// Backpressure: none; short or over-long frames are flagged with frame_err and dropped.
module panel_frame_receiver #(
  parameter int NUM_DEV     = panel_pkg::NUM_DEV,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sdi,
  input  logic                    sclk,
  input  logic                    lat,
  output logic [NUM_DEV-1:0][7:0] out_bytes,
  output logic                    frame_valid,
  output logic                    frame_err,
  output logic                    busy
);

  import panel_pkg::*;

  localparam int FB = 8 * NUM_DEV;
  localparam int CW = $clog2(FB + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(FB);
  localparam logic [CW-1:0] CNT_SAT  = CW'(FB + 1);

  logic          sdi_s;
  logic          sclk_rise;
  logic          lat_rise;
  logic          sdi_rise_unused;
  logic          sclk_q_unused;
  logic          lat_q_unused;

  logic [FB-1:0] shift_reg;
  logic [FB-1:0] shift_upd;
  logic [CW-1:0] bit_cnt;
  logic [CW-1:0] cnt_upd;
  rx_state_t     state;

  link_sync #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sync_sdi (
    .clk(clk), .rst(rst), .d(sdi), .q(sdi_s), .rise(sdi_rise_unused)
  );

  link_sync #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(sclk), .q(sclk_q_unused), .rise(sclk_rise)
  );

  link_sync #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_sync_lat (
    .clk(clk), .rst(rst), .d(lat), .q(lat_q_unused), .rise(lat_rise)
  );

  // Shift and count for this cycle; a coincident latch decides on these updated values.
  always_comb begin
    shift_upd = shift_reg;
    cnt_upd   = bit_cnt;
    if (sclk_rise) begin
      shift_upd = {shift_reg[FB-2:0], sdi_s};
      if (bit_cnt != CNT_SAT) begin
        cnt_upd = bit_cnt + 1'b1;
      end
    end
  end

  // Receive FSM: tracks frame fill level, publishes or rejects the frame on latch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_reg   <= '0;
      bit_cnt     <= '0;
      state       <= IDLE;
      out_bytes   <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      // The chain keeps shifting even past a full frame, so the newest FB bits survive.
      shift_reg   <= shift_upd;
      if (lat_rise) begin
        bit_cnt <= '0;
        state   <= IDLE;
        if (cnt_upd == CNT_FULL) begin
          out_bytes   <= shift_upd;
          frame_valid <= 1'b1;
        end else begin
          frame_err   <= 1'b1;
        end
      end else begin
        bit_cnt <= cnt_upd;
        case (state)
          IDLE:     if (sclk_rise) state <= SHIFTING;
          SHIFTING: if (sclk_rise && cnt_upd == CNT_FULL) state <= FULL;
          FULL:     if (sclk_rise) state <= OVERRUN;
          OVERRUN:  state <= OVERRUN;
          default:  state <= IDLE;
        endcase
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_panel_frame_receiver.sv
// Self-checking bench for panel_frame_receiver: directed scenarios plus random frames.
// Latency: n/a.
// Backpressure: n/a.
module tb_panel_frame_receiver;

  logic                clk = 1'b0;
  logic                rst;
  logic                sdi;
  logic                sclk;
  logic                lat;
  logic [15:0][7:0]    out_bytes;
  logic                frame_valid;
  logic                frame_err;
  logic                busy;

  always #5 clk = ~clk;

  panel_frame_receiver #(.NUM_DEV(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sdi(sdi), .sclk(sclk), .lat(lat),
    .out_bytes(out_bytes), .frame_valid(frame_valid),
    .frame_err(frame_err), .busy(busy)
  );

  int checks = 0;
  int fails  = 0;

  // Pulse bookkeeping sampled on the falling edge, away from DUT updates.
  int   vcnt = 0, ecnt = 0, both = 0, wide = 0;
  logic pv = 1'b0, pe = 1'b0;
  always @(negedge clk) begin
    if (frame_valid) vcnt++;
    if (frame_err) ecnt++;
    if (frame_valid && frame_err) both++;
    if ((frame_valid && pv) || (frame_err && pe)) wide++;
    pv = frame_valid;
    pe = frame_err;
  end

  // Reference model: bits received since the last latch, and the published frame.
  bit           rx_q[$];
  logic [127:0] exp_out = '0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_bit(input bit b);
    sdi = b;
    wait_cyc(3);
    sclk = 1'b1;
    rx_q.push_back(b);
    wait_cyc(3);
    sclk = 1'b0;
  endtask

  // Model latch decision: only an exact FRAME_BITS count publishes; the first bit lands at the MSB.
  task automatic model_latch(output bit good);
    good = (rx_q.size() == 128);
    if (good) begin
      for (int i = 0; i < 128; i++) exp_out[127-i] = rx_q[i];
    end
    rx_q.delete();
  endtask

  task automatic latch_and_check(input string tag);
    int v0, e0;
    bit good;
    v0 = vcnt;
    e0 = ecnt;
    model_latch(good);
    lat = 1'b1;
    wait_cyc(4);
    lat = 1'b0;
    wait_cyc(4);
    check({tag, "_valid"}, 128'(vcnt - v0), 128'(good));
    check({tag, "_err"},   128'(ecnt - e0), 128'(!good));
    check({tag, "_out"},   out_bytes, exp_out);
    check({tag, "_busy"},  128'(busy), 128'(0));
  endtask

  logic [127:0] nominal;
  logic [7:0]   a5;
  logic [127:0] ones;
  bit           lastb;
  bit           good;
  int           v0, e0, len;

  initial begin
    rst  = 1'b0;
    sdi  = 1'b0;
    sclk = 1'b0;
    lat  = 1'b0;
    wait_cyc(7);
    check("reset_out",   out_bytes, 128'(0));
    check("reset_busy",  128'(busy), 128'(0));
    check("reset_valid", 128'(vcnt), 128'(0));
    check("reset_err",   128'(ecnt), 128'(0));
    rst = 1'b1;
    wait_cyc(3);

    // Nominal frame, with a busy probe part way through.
    nominal = 128'h0000000B_0000000B_0000000B_0000000B;
    for (int i = 0; i < 128; i++) begin
      send_bit(nominal[127-i]);
      if (i == 9) begin
        wait_cyc(2);
        check("mid_busy", 128'(busy), 128'(1));
      end
    end
    latch_and_check("nominal");
    check("nominal_b0",  128'(out_bytes[0]),  128'(8'h0B));
    check("nominal_b12", 128'(out_bytes[12]), 128'(8'h0B));
    check("nominal_b1",  128'(out_bytes[1]),  128'(8'h00));

    // Idle latch with zero bits is an error.
    latch_and_check("idle_latch");

    // Short frame.
    for (int i = 0; i < 127; i++) send_bit(1'($urandom_range(0, 1)));
    latch_and_check("short");

    // Overrun: two leading ones then 128 bits of A5.
    a5 = 8'hA5;
    send_bit(1'b1);
    send_bit(1'b1);
    for (int i = 0; i < 128; i++) send_bit(a5[7-(i%8)]);
    latch_and_check("overrun");
    for (int i = 0; i < 128; i++) send_bit(1'($urandom_range(0, 1)));
    latch_and_check("after_overrun");

    // Coincident 128th sclk rise and lat rise.
    for (int i = 0; i < 127; i++) send_bit(1'($urandom_range(0, 1)));
    lastb = 1'($urandom_range(0, 1));
    v0 = vcnt;
    e0 = ecnt;
    sdi = lastb;
    wait_cyc(3);
    sclk = 1'b1;
    lat  = 1'b1;
    rx_q.push_back(lastb);
    model_latch(good);
    wait_cyc(4);
    sclk = 1'b0;
    lat  = 1'b0;
    wait_cyc(4);
    check("coinc_valid", 128'(vcnt - v0), 128'(good));
    check("coinc_err",   128'(ecnt - e0), 128'(0));
    check("coinc_out",   out_bytes, exp_out);
    check("coinc_lsb",   128'(out_bytes[0][0]), 128'(lastb));

    // Reset mid-frame discards the partial frame without a pulse.
    for (int i = 0; i < 64; i++) send_bit(1'($urandom_range(0, 1)));
    v0 = vcnt;
    e0 = ecnt;
    rst = 1'b0;
    rx_q.delete();
    exp_out = '0;
    wait_cyc(3);
    check("rstmid_out",  out_bytes, exp_out);
    check("rstmid_busy", 128'(busy), 128'(0));
    rst = 1'b1;
    wait_cyc(3);
    check("rstmid_valid", 128'(vcnt - v0), 128'(0));
    check("rstmid_err",   128'(ecnt - e0), 128'(0));
    for (int i = 0; i < 128; i++) send_bit(1'b1);
    latch_and_check("ones");
    ones = '1;
    check("ones_value", out_bytes, ones);

    // Random frames, mostly full length, sometimes short or long.
    for (int f = 0; f < 6; f++) begin
      len = ($urandom_range(0, 2) == 0) ? int'($urandom_range(120, 136)) : 128;
      for (int i = 0; i < len; i++) send_bit(1'($urandom_range(0, 1)));
      latch_and_check($sformatf("rand%0d", f));
    end

    check("pulse_overlap", 128'(both), 128'(0));
    check("pulse_width",   128'(wide), 128'(0));

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
